// File: rtl/display_scanner.sv
// Time-multiplexed 8-digit scanner feeding the 7-segment decoder; blinks the edited field in set mode.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a leading zero in the hour tens digit.
module display_scanner #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hourBcd,
  input  logic [7:0] minBcd,
  input  logic [7:0] secBcd,
  input  logic       mode12h,
  input  logic       isPm,
  input  logic [1:0] setField,
  output logic [3:0] showCode,
  output logic [7:0] an
);

  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [2:0]         digit_idx_q, digit_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [7:0]         an_q, an_d;
  logic [3:0]         show_code_q, show_code_d;

  logic       tick;
  logic [3:0] digit_code;
  logic [1:0] digit_field;
  logic       blank;

  // Out-of-range BCD must never reach the decoder as A/P or other glyphs.
  function automatic logic [3:0] bcd_nibble(input logic [3:0] n);
    return (n > 4'd9) ? 4'hF : n;
  endfunction

  always_comb begin
    tick          = (div_cnt_q == DIV_LAST);
    div_cnt_d     = tick ? '0 : div_cnt_q + DIV_W'(1);
    digit_idx_d   = tick ? digit_idx_q + 3'd1 : digit_idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    digit_code  = 4'hF;
    digit_field = 2'd0;
    case (digit_idx_q)
      3'd7: begin
        digit_field = 2'd1;
`ifdef LEADING_ZERO_BLANK_EN
        digit_code  = (hourBcd[7:4] == 4'd0) ? 4'hF : bcd_nibble(hourBcd[7:4]);
`else
        digit_code  = bcd_nibble(hourBcd[7:4]);
`endif
      end
      3'd6: begin digit_field = 2'd1; digit_code = bcd_nibble(hourBcd[3:0]); end
      3'd5: begin digit_field = 2'd2; digit_code = bcd_nibble(minBcd[7:4]);  end
      3'd4: begin digit_field = 2'd2; digit_code = bcd_nibble(minBcd[3:0]);  end
      3'd3: begin digit_field = 2'd3; digit_code = bcd_nibble(secBcd[7:4]);  end
      3'd2: begin digit_field = 2'd3; digit_code = bcd_nibble(secBcd[3:0]);  end
      3'd1: digit_code = 4'hF;
      default: digit_code = mode12h ? (isPm ? 4'hB : 4'hA) : 4'hF;
    endcase

    // Field 0 means "none", so it can never match a digit's field.
    blank       = blink_phase_q && (setField != 2'd0) && (digit_field == setField);
    an_d        = blank ? 8'hFF : ~(8'b1 << digit_idx_q);
    show_code_d = blank ? 4'hF : digit_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      digit_idx_q   <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= 8'hFF;
      show_code_q   <= 4'hF;
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      show_code_q   <= show_code_d;
    end
  end

  assign an       = an_q;
  assign showCode = show_code_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: directed plan cases plus random inputs against a cycle-count model.
module tb_display_scanner;

  localparam int SD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] hourBcd = 8'h00;
  logic [7:0] minBcd = 8'h00;
  logic [7:0] secBcd = 8'h00;
  logic       mode12h = 1'b0;
  logic       isPm = 1'b0;
  logic [1:0] setField = 2'd0;
  logic [3:0] showCode;
  logic [7:0] an;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;

  display_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .hourBcd(hourBcd), .minBcd(minBcd), .secBcd(secBcd),
    .mode12h(mode12h), .isPm(isPm), .setField(setField), .showCode(showCode), .an(an)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, edgeCount);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                               input logic m12, input logic pm, input logic [1:0] fld);
    hourBcd = h; minBcd = m; secBcd = s; mode12h = m12; isPm = pm; setField = fld;
  endtask

  // Reference: what one digit position should show, straight from the digit map.
  function automatic logic [3:0] modelDigit(input int d, input logic [7:0] h, input logic [7:0] m,
                                            input logic [7:0] s, input logic m12, input logic pm);
    int v;
    case (d)
      7: begin
        v = h / 16;
`ifdef LEADING_ZERO_BLANK_EN
        if (v == 0) v = 15;
`endif
      end
      6: v = h % 16;
      5: v = m / 16;
      4: v = m % 16;
      3: v = s / 16;
      2: v = s % 16;
      1: v = 15;
      default: v = m12 ? (pm ? 11 : 10) : 15;
    endcase
    if (d >= 2 && v > 9) v = 15;
    return 4'(v);
  endfunction

  // Output seen after edge k reflects the scan position held after k-1 edges.
  task automatic checkCycle();
    int pos, digit, phase, fieldOf;
    logic hide;
    logic [7:0] expAn;
    logic [3:0] expCode;
    pos = edgeCount - 1;
    digit = (pos / SD) % 8;
    phase = (pos / (SD * BD)) % 2;
    fieldOf = (digit >= 2) ? (4 - digit / 2) : 0;
    hide = (phase == 1) && (setField != 0) && (fieldOf == int'(setField));
    expAn = hide ? 8'hFF : ~(8'(1) << digit);
    expCode = hide ? 4'hF : modelDigit(digit, hourBcd, minBcd, secBcd, mode12h, isPm);
    checkOutput($sformatf("an[slot%0d]", digit), an, expAn);
    checkOutput($sformatf("code[slot%0d]", digit), {4'h0, showCode}, {4'h0, expCode});
  endtask

  task automatic runCycles(input int n, input bit randomize);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edgeCount++;
      #1;
      checkCycle();
      if (randomize && ($urandom_range(0, 3) == 0)) begin
        if ($urandom_range(0, 1) == 1)
          applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
        else
          applyStimulus({4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))},
                        {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))},
                        {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))},
                        1'($urandom), 1'($urandom), 2'($urandom));
      end
    end
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    edgeCount = 0;
  endtask

  initial begin
    bit reached;
    applyStimulus(8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 2'd0);
    repeat (3) @(negedge clk);
    checkOutput("resetAn", an, 8'hFF);
    checkOutput("resetCode", {4'h0, showCode}, 8'h0F);

    releaseReset();
    runCycles(8 * SD + 8, 1'b0);
    mode12h = 1'b0;
    runCycles(8 * SD, 1'b0);
    applyStimulus(8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 2'd2);
    runCycles(4 * 8 * SD, 1'b0);
    applyStimulus(8'h23, 8'h59, 8'hBA, 1'b0, 1'b0, 2'd0);
    runCycles(8 * SD, 1'b0);
    applyStimulus(8'h09, 8'h05, 8'h00, 1'b1, 1'b0, 2'd1);
    runCycles(4 * 8 * SD, 1'b0);
    runCycles(1200, 1'b1);

    applyStimulus(8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 2'd2);
    reached = 1'b0;
    for (int g = 0; g < 20 * SD * BD && !reached; g++) begin
      runCycles(1, 1'b0);
      if ((((edgeCount - 1) / SD) % 8 == 5) && ((edgeCount - 1) % SD == 1)) reached = 1'b1;
    end
    checkOutput("slot5Reached", {7'h0, reached}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetAn", an, 8'hFF);
    checkOutput("midResetCode", {4'h0, showCode}, 8'h0F);
    releaseReset();
    runCycles(4 * 8 * SD, 1'b0);
    runCycles(400, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
